// File: rtl/mist_video_timing_if.sv
// rtl/mist_video_timing_if.sv - control inputs and raster outputs of the video timing source
interface mist_video_timing_if #(
  parameter int COLOR_DEPTH = 6,
  parameter int HCNT_WIDTH  = 9,
  parameter int VCNT_WIDTH  = 9
);
  logic                   ce_divider;
  logic [1:0]             pattern_sel;
  logic                   ce_pix;
  logic [HCNT_WIDTH-1:0]  hcount;
  logic [VCNT_WIDTH-1:0]  vcount;
  logic                   hblank;
  logic                   vblank;
  logic                   HSync;
  logic                   VSync;
  logic                   frame_start;
  logic [COLOR_DEPTH-1:0] R;
  logic [COLOR_DEPTH-1:0] G;
  logic [COLOR_DEPTH-1:0] B;

  // Timing source side: takes the controls, drives the raster.
  modport master (
    input  ce_divider, pattern_sel,
    output ce_pix, hcount, vcount, hblank, vblank, HSync, VSync, frame_start, R, G, B
  );

  // Consumer side: drives the controls, receives the raster.
  modport slave (
    output ce_divider, pattern_sel,
    input  ce_pix, hcount, vcount, hblank, vblank, HSync, VSync, frame_start, R, G, B
  );
endinterface

// File: rtl/mist_video_timing.sv
// rtl/mist_video_timing.sv - 15 kHz raster timing generator with built-in test patterns
module mist_video_timing #(
  parameter int COLOR_DEPTH = 6,
  parameter int HCNT_WIDTH  = 9,
  parameter int VCNT_WIDTH  = 9,
  parameter int H_ACTIVE    = 256,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 24,
  parameter int H_BP        = 40,
  parameter int V_ACTIVE    = 224,
  parameter int V_FP        = 8,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 27
) (
  input  logic                clk_sys,
  input  logic                reset,
  mist_video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HCNT_WIDTH-1:0] H_LAST     = HCNT_WIDTH'(H_TOTAL - 1);
  localparam logic [HCNT_WIDTH-1:0] H_ACT_END  = HCNT_WIDTH'(H_ACTIVE);
  localparam logic [HCNT_WIDTH-1:0] H_SYNC_BEG = HCNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [HCNT_WIDTH-1:0] H_SYNC_END = HCNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCNT_WIDTH-1:0] BAR_LAST   = HCNT_WIDTH'(BAR_W - 1);
  localparam logic [VCNT_WIDTH-1:0] V_LAST     = VCNT_WIDTH'(V_TOTAL - 1);
  localparam logic [VCNT_WIDTH-1:0] V_ACT_END  = VCNT_WIDTH'(V_ACTIVE);
  localparam logic [VCNT_WIDTH-1:0] V_SYNC_BEG = VCNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [VCNT_WIDTH-1:0] V_SYNC_END = VCNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_DEPTH-1:0] MAX       = '1;

  logic [1:0]             div_q, div_d;
  logic                   ce_q, ce_d;
  logic [HCNT_WIDTH-1:0]  h_q, h_d;
  logic [VCNT_WIDTH-1:0]  v_q, v_d;
  logic [HCNT_WIDTH-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [1:0]             pat_q, pat_d;
  logic                   fs_q, fs_d;
  logic                   hblank_q, hblank_d;
  logic                   vblank_q, vblank_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   grid_on;

  // Next-state: pixel enable, raster counters, bar tracker and the decode of the new position.
  always_comb begin
    div_d     = div_q + 2'd1;
    // Odd divider phases for /2 and phase 3 for /4: since phase 3 is odd, a
    // mode change can never produce two enables in a row.
    ce_d      = vid.ce_divider ? div_q[0] : (div_q == 2'd3);
    h_d       = h_q;
    v_d       = v_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (ce_d) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // Bar index follows hcount / BAR_W without a divider.
      if (h_d == '0) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end

    fs_d     = ce_d && (h_d == '0) && (v_d == '0);
    // The pattern of a frame is fixed at its first pixel.
    pat_d    = fs_d ? vid.pattern_sel : pat_q;
    hblank_d = (h_d >= H_ACT_END);
    vblank_d = (v_d >= V_ACT_END);
    hs_d     = !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
    vs_d     = !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
    grid_on  = (h_d[3:0] == 4'd0) || (v_d[3:0] == 4'd0);

    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (pat_d)
      2'b00: begin
        // Bars white..black map to index bits: R=~idx[1], G=~idx[2], B=~idx[0].
        r_d = bar_idx_d[1] ? '0 : MAX;
        g_d = bar_idx_d[2] ? '0 : MAX;
        b_d = bar_idx_d[0] ? '0 : MAX;
      end
      2'b01: begin
        r_d = grid_on ? MAX : '0;
        g_d = grid_on ? MAX : '0;
        b_d = grid_on ? MAX : '0;
      end
      2'b10: begin
        r_d = h_d[COLOR_DEPTH-1:0];
        g_d = h_d[COLOR_DEPTH-1:0];
        b_d = h_d[COLOR_DEPTH-1:0];
      end
      default: ;
    endcase
    if (hblank_d || vblank_d) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // State update; the decoded outputs only move on a pixel enable so they track hcount/vcount.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q     <= 2'd0;
      ce_q      <= 1'b0;
      h_q       <= H_LAST;
      v_q       <= V_LAST;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= vid.pattern_sel;
      fs_q      <= 1'b0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      div_q     <= div_d;
      ce_q      <= ce_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      fs_q      <= fs_d;
      if (ce_d) begin
        hblank_q <= hblank_d;
        vblank_q <= vblank_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        r_q      <= r_d;
        g_q      <= g_d;
        b_q      <= b_d;
      end
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.hcount      = h_q;
  assign vid.vcount      = v_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.HSync       = hs_q;
  assign vid.VSync       = vs_q;
  assign vid.frame_start = fs_q;
  assign vid.R           = r_q;
  assign vid.G           = g_q;
  assign vid.B           = b_q;

endmodule

// File: tb/tb_mist_video_timing.sv
// tb/tb_mist_video_timing.sv - scoreboard bench for mist_video_timing (default and small raster)
module tb_mist_video_timing;

  typedef struct packed {
    int h; int v; int hb; int vb; int hs; int vs; int fs; int r; int g; int b;
  } pix_t;

  typedef struct packed {
    int ha; int hfp; int hs; int hb; int va; int vfp; int vs; int vb; int cd;
  } geo_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_a, rst_b;
  logic pos_a;
  int   cyc_a, cyc_b;
  int   line_prev_a, fs_prev_b;
  logic prev_ce_a, prev_ce_b;

  int   n_checks = 0;
  int   n_errors = 0;

  pix_t q_a[$];
  pix_t q_b[$];
  geo_t geo[2];
  int   mh[2], mv[2], mpat[2], mpend[2];

  mist_video_timing_if #(.COLOR_DEPTH(6), .HCNT_WIDTH(9), .VCNT_WIDTH(9)) va ();
  mist_video_timing_if #(.COLOR_DEPTH(4), .HCNT_WIDTH(5), .VCNT_WIDTH(4)) vb ();

  mist_video_timing dut_a (
    .clk_sys (clk_sys),
    .reset   (rst_a),
    .vid     (va)
  );

  mist_video_timing #(
    .COLOR_DEPTH(4), .HCNT_WIDTH(5), .VCNT_WIDTH(4),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset   (rst_b),
    .vid     (vb)
  );

  task automatic check_eq(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic pix_t model(geo_t gm, int h, int v, int pat);
    pix_t p;
    int   mx, c, on;
    p.h  = h;
    p.v  = v;
    p.hb = int'(h >= gm.ha);
    p.vb = int'(v >= gm.va);
    p.hs = int'(!(h >= gm.ha + gm.hfp && h < gm.ha + gm.hfp + gm.hs));
    p.vs = int'(!(v >= gm.va + gm.vfp && v < gm.va + gm.vfp + gm.vs));
    p.fs = int'(h == 0 && v == 0);
    p.r  = 0;
    p.g  = 0;
    p.b  = 0;
    mx   = (1 << gm.cd) - 1;
    if (p.hb == 0 && p.vb == 0) begin
      case (pat)
        0: begin
          case (h / (gm.ha / 8))
            0: c = 7;  1: c = 6;  2: c = 3;  3: c = 2;
            4: c = 5;  5: c = 4;  6: c = 1;  default: c = 0;
          endcase
          p.r = ((c >> 2) & 1) != 0 ? mx : 0;
          p.g = ((c >> 1) & 1) != 0 ? mx : 0;
          p.b = (c & 1) != 0 ? mx : 0;
        end
        1: begin
          on  = int'((h % 16) == 0 || (v % 16) == 0);
          p.r = on != 0 ? mx : 0;
          p.g = p.r;
          p.b = p.r;
        end
        2: begin
          p.r = h % (1 << gm.cd);
          p.g = p.r;
          p.b = p.r;
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  task automatic model_reset(int d, int pat);
    mh[d]    = geo[d].ha + geo[d].hfp + geo[d].hs + geo[d].hb - 1;
    mv[d]    = geo[d].va + geo[d].vfp + geo[d].vs + geo[d].vb - 1;
    mpat[d]  = pat;
    mpend[d] = pat;
  endtask

  task automatic push_px(int d, int n);
    int ht, vt;
    ht = geo[d].ha + geo[d].hfp + geo[d].hs + geo[d].hb;
    vt = geo[d].va + geo[d].vfp + geo[d].vs + geo[d].vb;
    for (int i = 0; i < n; i++) begin
      if (mh[d] == ht - 1) begin
        mh[d] = 0;
        mv[d] = (mv[d] == vt - 1) ? 0 : mv[d] + 1;
      end else begin
        mh[d] = mh[d] + 1;
      end
      if (mh[d] == 0 && mv[d] == 0) mpat[d] = mpend[d];
      if (d == 0) q_a.push_back(model(geo[d], mh[d], mv[d], mpat[d]));
      else        q_b.push_back(model(geo[d], mh[d], mv[d], mpat[d]));
    end
  endtask

  task automatic wait_drain(int d, int budget);
    int n = 0;
    while ((d == 0 ? q_a.size() : q_b.size()) != 0 && n < budget) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    check_eq(d == 0 ? "A.drain_timeout" : "B.drain_timeout", int'(n >= budget), 0);
  endtask

  task automatic cmp_pix(string w, pix_t e, pix_t a);
    check_eq({w, ".hcount"}, a.h, e.h);
    check_eq({w, ".vcount"}, a.v, e.v);
    check_eq({w, ".hblank"}, a.hb, e.hb);
    check_eq({w, ".vblank"}, a.vb, e.vb);
    check_eq({w, ".HSync"}, a.hs, e.hs);
    check_eq({w, ".VSync"}, a.vs, e.vs);
    check_eq({w, ".frame_start"}, a.fs, e.fs);
    check_eq({w, ".R"}, a.r, e.r);
    check_eq({w, ".G"}, a.g, e.g);
    check_eq({w, ".B"}, a.b, e.b);
  endtask

  function automatic pix_t grab_a();
    pix_t p;
    p = '{h: int'(va.hcount), v: int'(va.vcount), hb: int'(va.hblank), vb: int'(va.vblank),
          hs: int'(va.HSync), vs: int'(va.VSync), fs: int'(va.frame_start),
          r: int'(va.R), g: int'(va.G), b: int'(va.B)};
    return p;
  endfunction

  function automatic pix_t grab_b();
    pix_t p;
    p = '{h: int'(vb.hcount), v: int'(vb.vcount), hb: int'(vb.hblank), vb: int'(vb.vblank),
          hs: int'(vb.HSync), vs: int'(vb.VSync), fs: int'(vb.frame_start),
          r: int'(vb.R), g: int'(vb.G), b: int'(vb.B)};
    return p;
  endfunction

  function automatic int exp_ce(int cyc, logic div2);
    if (cyc == 0) return 0;
    return div2 ? int'(cyc % 2 == 0) : int'(cyc % 4 == 0);
  endfunction

  task automatic check_reset_a();
    check_eq("A.rst_hcount", int'(va.hcount), 335);
    check_eq("A.rst_vcount", int'(va.vcount), 261);
    check_eq("A.rst_hblank", int'(va.hblank), 1);
    check_eq("A.rst_vblank", int'(va.vblank), 1);
    check_eq("A.rst_HSync", int'(va.HSync), 1);
    check_eq("A.rst_VSync", int'(va.VSync), 1);
    check_eq("A.rst_ce_pix", int'(va.ce_pix), 0);
    check_eq("A.rst_frame_start", int'(va.frame_start), 0);
    check_eq("A.rst_rgb", int'({va.R, va.G, va.B}), 0);
  endtask

  always @(posedge clk_sys) begin
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
  end

  // Scoreboard and enable-timing monitor for the default-size raster.
  always @(negedge clk_sys) begin
    if (rst_a) begin
      prev_ce_a   <= 1'b0;
      line_prev_a <= -1;
    end else begin
      check_eq("A.ce_back_to_back", int'(va.ce_pix && prev_ce_a), 0);
      if (pos_a) check_eq("A.ce_position", int'(va.ce_pix), exp_ce(cyc_a, va.ce_divider));
      if (va.ce_pix) begin
        if (q_a.size() == 0) check_eq("A.unexpected_pixel", 1, 0);
        else cmp_pix("A", q_a.pop_front(), grab_a());
        if (va.hcount == 9'd0) begin
          if (pos_a && line_prev_a >= 0) check_eq("A.line_length", cyc_a - line_prev_a, 1344);
          line_prev_a <= cyc_a;
        end
      end else begin
        check_eq("A.frame_start_idle", int'(va.frame_start), 0);
      end
      prev_ce_a <= va.ce_pix;
    end
  end

  // Scoreboard and frame-length monitor for the small raster (24 x 10 pixels).
  always @(negedge clk_sys) begin
    if (rst_b) begin
      prev_ce_b <= 1'b0;
      fs_prev_b <= -1;
    end else begin
      check_eq("B.ce_back_to_back", int'(vb.ce_pix && prev_ce_b), 0);
      check_eq("B.ce_position", int'(vb.ce_pix), exp_ce(cyc_b, vb.ce_divider));
      if (vb.ce_pix) begin
        if (q_b.size() == 0) check_eq("B.unexpected_pixel", 1, 0);
        else cmp_pix("B", q_b.pop_front(), grab_b());
      end else begin
        check_eq("B.frame_start_idle", int'(vb.frame_start), 0);
      end
      if (vb.frame_start) begin
        if (fs_prev_b >= 0) check_eq("B.frame_length", cyc_b - fs_prev_b, (vb.ce_divider ? 2 : 4) * 240);
        fs_prev_b <= cyc_b;
      end
      prev_ce_b <= vb.ce_pix;
    end
  end

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pos_a = 1'b1;
    va.ce_divider  = 1'b0;
    va.pattern_sel = 2'b00;
    vb.ce_divider  = 1'b0;
    vb.pattern_sel = 2'b00;
    geo[0] = '{ha: 256, hfp: 16, hs: 24, hb: 40, va: 224, vfp: 8, vs: 3, vb: 27, cd: 6};
    geo[1] = '{ha: 16, hfp: 2, hs: 3, hb: 3, va: 6, vfp: 1, vs: 2, vb: 1, cd: 4};

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset_a();
    check_eq("B.rst_hcount", int'(vb.hcount), 23);
    check_eq("B.rst_vcount", int'(vb.vcount), 9);

    // Default raster: line 0 in full, then line 1 up to hcount 40.
    model_reset(0, 0);
    push_px(0, 377);
    @(posedge clk_sys);
    #1 rst_a = 1'b0;
    wait_drain(0, 4000);

    // One-cycle reset mid-line.
    @(posedge clk_sys);
    #1 rst_a = 1'b1;
    @(posedge clk_sys);
    #1 rst_a = 1'b0;
    model_reset(0, 0);
    push_px(0, 337);
    @(negedge clk_sys);
    check_reset_a();
    wait_drain(0, 4000);

    // Toggle the divider select mid-line; pixel content must not care.
    pos_a = 1'b0;
    push_px(0, 200);
    n = 0;
    while (q_a.size() != 0 && n < 2000) begin
      @(posedge clk_sys);
      #1;
      if (n % 7 == 3) va.ce_divider = ~va.ce_divider;
      n++;
    end
    check_eq("A.toggle_drain_timeout", int'(n >= 2000), 0);
    rst_a = 1'b1;

    // Small raster: bars, switch to grey ramp mid-frame, effective next frame.
    model_reset(1, 0);
    push_px(1, 73);
    @(posedge clk_sys);
    #1 rst_b = 1'b0;
    wait_drain(1, 1000);
    vb.pattern_sel = 2'b10;
    mpend[1] = 2;
    push_px(1, 647);
    wait_drain(1, 4000);

    // Restart at clk/2 with the grid, then switch to black.
    @(posedge clk_sys);
    #1 rst_b = 1'b1;
    vb.ce_divider  = 1'b1;
    vb.pattern_sel = 2'b01;
    @(posedge clk_sys);
    #1 rst_b = 1'b0;
    model_reset(1, 1);
    push_px(1, 481);
    wait_drain(1, 2000);
    vb.pattern_sel = 2'b11;
    mpend[1] = 3;
    push_px(1, 260);
    wait_drain(1, 2000);
    rst_b = 1'b1;

    @(posedge clk_sys);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
